ta_cap_seq: RTL and testbench

- Capture sequencer for the ADC/LDD capture subsystem, running on a single clock.
- Power-sequences the ADC and laser-driver enables and issues laser capture triggers.
- Steps the capture phase across a programmed sweep and signals completion to the memory side.
- Supervises each shot with a timeout and exposes status to the host register block.

---
 rtl/ta_cap_seq.sv | 173 +++++++++++++++++
 tb/tb_ta_cap_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ta_cap_seq.sv
// ta_cap_seq -- capture sequencer for the ADC/LDD capture subsystem.
//
// Brings up the ADC enable, waits SETTLE cycles, then enables the laser
// driver. It issues one cap_trig per shot and steps cap_phase across the
// programmed sweep. Each wait for capr_rdy or frame_done has a timeout.
//
// Ports
//   clki, rsti_n      clock, async active-low reset
//   start, abort      run request (1-cycle, IDLE only) / level abort
//   cfg_*             run configuration, latched on the accepted start
//   capr_rdy          trigger path ready
//   frame_done        1-cycle pulse: current shot stored
//   adc_en, ldd_en    power enables
//   cap_trig          1-cycle trigger pulse
//   cap_phase         current capture phase
//   cap_cmpt          1-cycle pulse at normal end of capture
//   busy              any state but IDLE
//   err_tmo           sticky timeout flag
//   shot_total        frames completed in current/last run (saturating)
module ta_cap_seq #(
   parameter int PHASE_W = 2,
   parameter int SHOT_W  = 8,
   parameter int GAP_W   = 16,
   parameter int TMO_W   = 16,
   parameter int SETTLE  = 1000
) (
   input  logic                      clki,
   input  logic                      rsti_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [SHOT_W-1:0]         cfg_shots,
   input  logic [GAP_W-1:0]          cfg_gap,
   input  logic [TMO_W-1:0]          cfg_tmo,
   input  logic                      cfg_sweep,
   input  logic [PHASE_W-1:0]        cfg_phase,
   input  logic                      capr_rdy,
   input  logic                      frame_done,
   output logic                      adc_en,
   output logic                      ldd_en,
   output logic                      cap_trig,
   output logic [PHASE_W-1:0]        cap_phase,
   output logic                      cap_cmpt,
   output logic                      busy,
   output logic                      err_tmo,
   output logic [SHOT_W+PHASE_W-1:0] shot_total
);

   // One shared cycle counter serves the settle, gap and timeout waits.
   localparam int SET_W = $clog2(SETTLE + 1);
   localparam int GT_W  = (GAP_W > TMO_W) ? GAP_W : TMO_W;
   localparam int CNT_W = (GT_W > SET_W) ? GT_W : SET_W;

   typedef enum logic [2:0] {
      S_IDLE, S_PWR, S_ARM, S_TRIG, S_WAIT, S_GAP, S_FIN
   } state_t;

   state_t state, state_nxt;

   logic [SHOT_W-1:0]  shots_q, pcnt;
   logic [GAP_W-1:0]   gap_q;
   logic [TMO_W-1:0]   tmo_q;
   logic               sweep_q;
   logic [PHASE_W-1:0] ph_idx;   // phases finished so far in this sweep
   logic [CNT_W-1:0]   cnt;

   logic               accept, frame_ok, step_phase, tmo_hit, tmo_exp;
   logic [SHOT_W-1:0]  pcnt_inc;

   assign pcnt_inc = pcnt + SHOT_W'(1);
   // Expiry is flagged in the last counted cycle, so that err_tmo rises
   // exactly cfg_tmo cycles after entry into the waiting state.
   assign tmo_exp  = (tmo_q != '0) && (cnt == CNT_W'(tmo_q) - CNT_W'(1));

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      frame_ok   = 1'b0;
      step_phase = 1'b0;
      tmo_hit    = 1'b0;
      case (state)
         S_IDLE: if (start) begin
            state_nxt = S_PWR;
            accept    = 1'b1;
         end
         S_PWR:  if (cnt == CNT_W'(SETTLE - 1)) state_nxt = S_ARM;
         S_ARM: begin
            if (shots_q == '0)  state_nxt = S_FIN;
            else if (capr_rdy)  state_nxt = S_TRIG;
            else if (tmo_exp) begin
               state_nxt = S_IDLE;
               tmo_hit   = 1'b1;
            end
         end
         S_TRIG: state_nxt = S_WAIT;
         S_WAIT: begin
            // A frame arriving in the expiry cycle takes precedence.
            if (frame_done) begin
               frame_ok = 1'b1;
               if (pcnt_inc < shots_q) begin
                  state_nxt = S_GAP;
               end else if (sweep_q && (ph_idx != '1)) begin
                  state_nxt  = S_GAP;
                  step_phase = 1'b1;
               end else begin
                  state_nxt = S_FIN;
               end
            end else if (tmo_exp) begin
               state_nxt = S_IDLE;
               tmo_hit   = 1'b1;
            end
         end
         // GAP lasts cfg_gap+1 cycles, including the cycle that exits it.
         S_GAP:  if (cnt == CNT_W'(gap_q)) state_nxt = S_ARM;
         S_FIN:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort && (state != S_IDLE)) begin
         state_nxt  = S_IDLE;
         frame_ok   = 1'b0;
         step_phase = 1'b0;
         tmo_hit    = 1'b0;
      end
   end

   always_comb begin
      busy     = (state != S_IDLE);
      adc_en   = (state != S_IDLE);
      ldd_en   = (state != S_IDLE) && (state != S_PWR);
      cap_trig = (state == S_TRIG);
      cap_cmpt = (state == S_FIN);
   end

   always_ff @(posedge clki or negedge rsti_n) begin
      if (!rsti_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         shots_q    <= '0;
         gap_q      <= '0;
         tmo_q      <= '0;
         sweep_q    <= 1'b0;
         cap_phase  <= '0;
         ph_idx     <= '0;
         pcnt       <= '0;
         err_tmo    <= 1'b0;
         shot_total <= '0;
      end else begin
         state <= state_nxt;
         // Restart on every state change, so each wait counts from its entry.
         cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
         if (accept) begin
            shots_q    <= cfg_shots;
            gap_q      <= cfg_gap;
            tmo_q      <= cfg_tmo;
            sweep_q    <= cfg_sweep;
            cap_phase  <= cfg_phase;
            ph_idx     <= '0;
            pcnt       <= '0;
            err_tmo    <= 1'b0;
            shot_total <= '0;
         end
         if (frame_ok) begin
            if (shot_total != '1) shot_total <= shot_total + 1'b1;
            pcnt <= step_phase ? '0 : pcnt_inc;
         end
         if (step_phase) begin
            cap_phase <= cap_phase + 1'b1;
            ph_idx    <= ph_idx + 1'b1;
         end
         if (tmo_hit) err_tmo <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ta_cap_seq.sv
// Self-checking bench for ta_cap_seq. A responder returns frame_done a
// programmed delay after each trigger and drives capr_rdy. A monitor logs
// the triggers and completions. The expected trigger phase list comes from
// the sweep rules.
module tb_ta_cap_seq;
   localparam int PW = 2, SW = 8, GW = 16, TW = 16, SETTLE = 1000;
   localparam int NPH = 1 << PW;

   logic clki = 1'b0, rsti_n = 1'b0;
   logic start = 1'b0, abort = 1'b0, cfg_sweep = 1'b0;
   logic [SW-1:0] cfg_shots = '0;
   logic [GW-1:0] cfg_gap = '0;
   logic [TW-1:0] cfg_tmo = '0;
   logic [PW-1:0] cfg_phase = '0;
   logic capr_rdy, frame_done;
   logic adc_en, ldd_en, cap_trig, cap_cmpt, busy, err_tmo;
   logic [PW-1:0] cap_phase;
   logic [SW+PW-1:0] shot_total;

   ta_cap_seq #(.PHASE_W(PW), .SHOT_W(SW), .GAP_W(GW), .TMO_W(TW), .SETTLE(SETTLE)) dut (
      .clki(clki), .rsti_n(rsti_n), .start(start), .abort(abort),
      .cfg_shots(cfg_shots), .cfg_gap(cfg_gap), .cfg_tmo(cfg_tmo),
      .cfg_sweep(cfg_sweep), .cfg_phase(cfg_phase), .capr_rdy(capr_rdy),
      .frame_done(frame_done), .adc_en(adc_en), .ldd_en(ldd_en),
      .cap_trig(cap_trig), .cap_phase(cap_phase), .cap_cmpt(cap_cmpt),
      .busy(busy), .err_tmo(err_tmo), .shot_total(shot_total));

   initial forever #5 clki = ~clki;

   int cyc = 0;
   always @(posedge clki) cyc <= cyc + 1;

   int n_tests = 0, n_fail = 0;
   int fd_delay = 0;      // 0 = never return frame_done
   int rdy_rand = 0;
   logic rdy_hold = 1'b1;
   int trig_q[$], trig_cyc_q[$], exp_q[$];
   int cmpt_n = 0, cmpt_cyc = 0, bad_trig = 0;

   // Responder: frame_done exactly fd_delay cycles after a trigger.
   initial begin
      int fd_cnt;
      fd_cnt = 0; frame_done = 1'b0; capr_rdy = 1'b0;
      forever begin
         @(negedge clki);
         frame_done = 1'b0;
         if (fd_cnt > 0) begin
            fd_cnt--;
            if (fd_cnt == 0) frame_done = 1'b1;
         end
         if (cap_trig && fd_delay > 0) fd_cnt = fd_delay;
         capr_rdy = (rdy_rand != 0) ? 1'($urandom_range(0, 1)) : rdy_hold;
      end
   end

   // Monitor
   initial forever begin
      @(negedge clki);
      if (cap_trig) begin
         trig_q.push_back(int'(cap_phase));
         trig_cyc_q.push_back(cyc);
         if (!ldd_en) bad_trig++;
      end
      if (cap_cmpt) begin
         cmpt_n++;
         cmpt_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns the start cycle. Inputs are scrambled
   // afterwards, and the run must ignore the new values.
   task automatic start_run(input int shots, input int gap, input int tmo,
                            input int sweep, input int phase, output int t);
      cfg_shots = SW'(shots); cfg_gap = GW'(gap); cfg_tmo = TW'(tmo);
      cfg_sweep = 1'(sweep); cfg_phase = PW'(phase);
      start = 1'b1; t = cyc;
      @(negedge clki);
      start = 1'b0;
      cfg_shots = SW'($urandom); cfg_gap = GW'($urandom); cfg_tmo = TW'($urandom);
      cfg_sweep = 1'($urandom); cfg_phase = PW'($urandom);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < SETTLE + 3000) begin @(negedge clki); k++; end
      chk({tag, " idle_bound"}, busy, 0);
   endtask

   // Reference: every phase of the sweep (or just the fixed one) gets `shots` triggers.
   task automatic model(input int shots, input int sweep, input int phase);
      exp_q.delete();
      for (int p = 0; p < ((sweep != 0) ? NPH : 1); p++)
         for (int s = 0; s < shots; s++) exp_q.push_back((phase + p) % NPH);
   endtask

   task automatic check_run(input string tag, input int n0, input int c0, input int spacing);
      chk({tag, " ntrig"}, trig_q.size() - n0, exp_q.size());
      for (int i = 0; i < exp_q.size() && n0 + i < trig_q.size(); i++) begin
         chk({tag, " phase"}, trig_q[n0 + i], exp_q[i]);
         if (spacing > 0 && i > 0)
            chk({tag, " spacing"}, trig_cyc_q[n0 + i] - trig_cyc_q[n0 + i - 1], spacing);
      end
      chk({tag, " shot_total"}, shot_total, exp_q.size());
      chk({tag, " cmpt_n"}, cmpt_n - c0, 1);
      chk({tag, " err"}, err_tmo, 0);
   endtask

   initial begin
      int t, k, n0, c0, tr;
      // reset state
      repeat (3) @(negedge clki);
      chk("rst outs", {adc_en, ldd_en, cap_trig, cap_cmpt, busy, err_tmo}, 0);
      chk("rst total", shot_total, 0);
      chk("rst phase", cap_phase, 0);
      rsti_n = 1'b1;
      @(negedge clki);
      chk("post rst busy", busy, 0);

      // Fixed phase 2, 3 shots, gap 4, frame 10 after trig, power timing
      fd_delay = 10; rdy_hold = 1'b1;
      n0 = trig_q.size(); c0 = cmpt_n;
      start_run(3, 4, 0, 0, 2, t);
      chk("pwr adc t+1", adc_en, 1);
      chk("pwr busy t+1", busy, 1);
      chk("pwr ldd t+1", ldd_en, 0);
      k = 0;
      while (!ldd_en && k < SETTLE + 20) begin @(negedge clki); k++; end
      chk("pwr ldd cycle", cyc, t + 1 + SETTLE);
      wait_idle("fixed");
      model(3, 0, 2);
      check_run("fixed", n0, c0, 10 + 1 + 4 + 1 + 1);
      if (trig_q.size() > 0) chk("fixed cmpt cyc", cmpt_cyc, trig_cyc_q[$] + 11);
      chk("fixed busy after cmpt", cyc, cmpt_cyc + 1);
      chk("fixed adc off", adc_en, 0);

      // Sweep from phase 3, 2 shots per phase
      fd_delay = 3;
      n0 = trig_q.size(); c0 = cmpt_n;
      start_run(2, 1, 0, 1, 3, t);
      wait_idle("sweep");
      model(2, 1, 3);
      check_run("sweep", n0, c0, 3 + 1 + 1 + 1 + 1);

      // Timeout in WAIT: frame_done never returned
      fd_delay = 0;
      n0 = trig_q.size(); c0 = cmpt_n;
      start_run(2, 0, 50, 0, 0, t);
      k = 0;
      while (!err_tmo && k < SETTLE + 200) begin @(negedge clki); k++; end
      tr = (trig_q.size() > n0) ? trig_cyc_q[n0] : -1;
      chk("tmo err cycle", cyc, tr + 1 + 50);
      chk("tmo enables", {adc_en, ldd_en, busy}, 0);
      chk("tmo no cmpt", cmpt_n - c0, 0);
      chk("tmo total", shot_total, 0);

      // Abort during GAP after one frame; start in-run is ignored
      fd_delay = 5;
      n0 = trig_q.size(); c0 = cmpt_n;
      start_run(3, 20, 0, 0, 1, t);
      chk("start clears err", err_tmo, 0);
      k = 0;
      while (shot_total != 1 && k < SETTLE + 200) begin @(negedge clki); k++; end
      chk("abort reach gap", shot_total, 1);
      start = 1'b1;
      @(negedge clki);
      start = 1'b0; abort = 1'b1;
      @(negedge clki);
      abort = 1'b0;
      chk("abort outs", {adc_en, ldd_en, busy, cap_cmpt}, 0);
      chk("abort total", shot_total, 1);
      repeat (5) @(negedge clki);
      chk("abort stays idle", busy, 0);
      chk("abort ntrig", trig_q.size() - n0, 1);
      chk("abort no cmpt", cmpt_n - c0, 0);

      // shots = 0: no trigger, cap_cmpt one cycle after ARM entry
      n0 = trig_q.size(); c0 = cmpt_n;
      start_run(0, 0, 0, 1, 0, t);
      k = 0;
      while (!ldd_en && k < SETTLE + 20) begin @(negedge clki); k++; end
      chk("z0 arm cmpt", cap_cmpt, 0);
      @(negedge clki);
      chk("z0 cmpt", cap_cmpt, 1);
      wait_idle("z0");
      chk("z0 ntrig", trig_q.size() - n0, 0);
      chk("z0 total", shot_total, 0);

      // frame_done in the expiry cycle wins over the timeout
      fd_delay = 20;
      n0 = trig_q.size(); c0 = cmpt_n;
      start_run(1, 0, 20, 0, 0, t);
      wait_idle("tie");
      model(1, 0, 0);
      check_run("tie", n0, c0, 0);

      // one cycle later the timeout wins; the late frame_done is ignored
      fd_delay = 21;
      c0 = cmpt_n;
      start_run(1, 0, 20, 0, 0, t);
      wait_idle("late");
      repeat (3) @(negedge clki);
      chk("late err", err_tmo, 1);
      chk("late total", shot_total, 0);
      chk("late no cmpt", cmpt_n - c0, 0);

      // Randomized runs, random capr_rdy
      rdy_rand = 1;
      for (int r = 0; r < 4; r++) begin
         int shots, gap, sweep, phase;
         shots = $urandom_range(0, 3); gap = $urandom_range(0, 5);
         sweep = $urandom_range(0, 1); phase = $urandom_range(0, NPH - 1);
         fd_delay = $urandom_range(1, 8);
         n0 = trig_q.size(); c0 = cmpt_n;
         start_run(shots, gap, 0, sweep, phase, t);
         wait_idle("rand");
         model(shots, sweep, phase);
         check_run("rand", n0, c0, 0);
      end
      rdy_rand = 0;
      chk("trig before ldd_en", bad_trig, 0);

      // Asynchronous reset mid-run
      start_run(2, 0, 0, 0, 1, t);
      repeat (5) @(negedge clki);
      chk("arst pre adc", adc_en, 1);
      chk("arst pre phase", cap_phase, 1);
      #3 rsti_n = 1'b0;
      #1;
      chk("arst outs", {adc_en, ldd_en, cap_trig, cap_cmpt, busy, err_tmo}, 0);
      chk("arst total/phase", {shot_total, cap_phase}, 0);
      @(negedge clki);
      rsti_n = 1'b1;
      repeat (2) @(negedge clki);
      chk("arst stays idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
